// File: rtl/key_hash.sv
// key_hash: iterative 64-bit key to table-index hash.
// Consumes one key byte per clock (byte 0 = key_i[63:56] first), mixing it into
// a 32-bit accumulator with a rotate-left-by-5 and XOR. After byte 7 the
// accumulator is folded (h ^ h>>16) and truncated to HASH_BITS bits.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | no computation in flight; outputs hold the last result
//  RUN   | mixing one key byte per edge, cnt = index of the next byte
module key_hash #(
   parameter int HASH_BITS = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [63:0] key_i,
   output logic        hash_ready_o,
   output logic [31:0] hash_val_o
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [63:0] key_q;
   logic [31:0] h_q;
   logic [2:0]  cnt_q;

   logic [31:0] h_next;
   logic [31:0] h_fold;
   logic [31:0] hash_idx;
   logic        last_byte;

   // State register; reset wins over start.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state: start always (re)enters RUN, byte 7 returns to IDLE.
   always_comb begin
      state_d = state_q;
      if (start_i) begin
         state_d = RUN;
      end else begin
         case (state_q)
            IDLE: state_d = IDLE;
            RUN:  if (last_byte) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Mixing step and final fold; the key register shifts left so the
   // byte to process is always in its top 8 bits.
   always_comb begin
      h_next    = {h_q[26:0], h_q[31:27]} ^ {24'b0, key_q[63:56]};
      h_fold    = h_next ^ (h_next >> 16);
      last_byte = (cnt_q == 3'd7);
      hash_idx  = {{(32-HASH_BITS){1'b0}}, h_fold[HASH_BITS-1:0]};
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_q        <= '0;
         h_q          <= '0;
         cnt_q        <= '0;
         hash_ready_o <= 1'b0;
         hash_val_o   <= '0;
      end else if (start_i) begin
         key_q        <= key_i;
         h_q          <= '0;
         cnt_q        <= '0;
         hash_ready_o <= 1'b0;
      end else if (state_q == RUN) begin
         key_q <= {key_q[55:0], 8'h00};
         h_q   <= h_next;
         cnt_q <= 3'(cnt_q + 3'd1);
         if (last_byte) begin
            hash_val_o   <= hash_idx;
            hash_ready_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_key_hash.sv
// Directed + random bench for key_hash against a plain arithmetic hash model.
module tb_key_hash;
   localparam int HB = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [63:0] key_i;
   logic        hash_ready_o;
   logic [31:0] hash_val_o;

   int checks = 0;
   int errors = 0;

   key_hash #(.HASH_BITS(HB)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .key_i        (key_i),
      .hash_ready_o (hash_ready_o),
      .hash_val_o   (hash_val_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [63:0] key);
      longint unsigned h = 0;
      longint unsigned b;
      for (int i = 0; i < 8; i++) begin
         b = (key >> (56 - 8*i)) & 64'hFF;
         h = (((h << 5) | (h >> 27)) & 64'hFFFF_FFFF) ^ b;
      end
      h = h ^ (h >> 16);
      return 32'(h % (64'd1 << HB));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Wait for ready after the sampling edge; returns edges taken (0 = timeout).
   task automatic wait_ready(output int lat);
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (hash_ready_o === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic run_key(input string tag, input logic [63:0] key);
      int lat;
      logic [31:0] exp;
      exp     = model(key);
      key_i   = key;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      key_i   = {$urandom, $urandom};
      check({tag, "_ready_low"}, 32'(hash_ready_o), 32'd0);
      wait_ready(lat);
      check({tag, "_latency"}, 32'(lat), 32'd8);
      check({tag, "_value"}, hash_val_o, exp);
   endtask

   initial begin
      int lat;
      logic [63:0] k;
      logic [31:0] v_hold;
      rst = 1'b1; start_i = 1'b0; key_i = '0;
      tick(); tick();
      rst = 1'b0;
      check("reset_ready", 32'(hash_ready_o), 32'd0);
      check("reset_val", hash_val_o, 32'd0);
      for (int i = 0; i < 20; i++) tick();
      check("idle_ready", 32'(hash_ready_o), 32'd0);
      check("idle_val", hash_val_o, 32'd0);

      // Directed keys with hand-computed expectations.
      run_key("key_1", 64'h0000_0000_0000_0001);
      check("key_1_const", hash_val_o, 32'h1);
      for (int i = 0; i < 5; i++) tick();
      check("key_1_hold_ready", 32'(hash_ready_o), 32'd1);
      check("key_1_hold_val", hash_val_o, 32'h1);
      run_key("key_b0_1", 64'h0100_0000_0000_0000);
      check("key_b0_1_const", hash_val_o, 32'h8);
      run_key("key_b0_a", 64'h0A00_0000_0000_0000);
      check("key_b0_a_const", hash_val_o, 32'h50);
      run_key("key_0", 64'h0);
      check("key_0_const", hash_val_o, 32'h0);

      // Back-to-back: key A, then key B three edges later.
      k = 64'hDEAD_BEEF_0123_4567;
      run_key("pre_b2b", k);
      key_i = 64'hFFEE_DDCC_BBAA_9988; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("b2b_a_ready_low", 32'(hash_ready_o), 32'd0);
      tick(); tick();
      check("b2b_a_no_ready", 32'(hash_ready_o), 32'd0);
      run_key("b2b_b", 64'h0000_0000_0000_0001);
      check("b2b_b_const", hash_val_o, 32'h1);

      // Multi-cycle start: result belongs to the key of the last high edge.
      start_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         key_i = {$urandom, $urandom};
         k = key_i;
         tick();
      end
      start_i = 1'b0;
      wait_ready(lat);
      check("multi_start_latency", 32'(lat), 32'd8);
      check("multi_start_value", hash_val_o, model(k));

      // Reset in the middle of a computation.
      key_i = 64'h1234_5678_9ABC_DEF0; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_ready", 32'(hash_ready_o), 32'd0);
      check("midrst_val", hash_val_o, 32'd0);
      for (int i = 0; i < 12; i++) tick();
      check("midrst_no_ready", 32'(hash_ready_o), 32'd0);
      check("midrst_val_hold", hash_val_o, 32'd0);
      run_key("post_rst", 64'h1234_5678_9ABC_DEF0);

      // Random keys; also bound check and determinism on a repeat.
      for (int i = 0; i < 30; i++) begin
         k = {$urandom, $urandom};
         run_key("rand", k);
         check("rand_upper_zero", hash_val_o >> HB, 32'd0);
         if (i == 0) v_hold = hash_val_o;
         if (i == 0) begin
            run_key("rand_repeat", k);
            check("rand_repeat_same", hash_val_o, v_hold);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/key_hash.md
Name: key_hash

Overview:
- Iterative 64-bit-key to table-index hash engine used by the flow-table matcher.
- Matcher pulses start with an 8-byte key (tag, zero, 6 key bytes) and waits for ready.
- Matcher then uses hash_val_o as an entry index: address = table_base + hash_val_o * entry_len.
- Output is bounded to 2^HASH_BITS entries, zero-extended to 32 bits.

Parameters:
- HASH_BITS, 10, index width. Legal 1..16. hash_val_o[31:HASH_BITS] is always 0.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  request pulse; key_i is sampled on a rising edge where start_i=1.
- key_i  input  64  key; byte 0 is key_i[63:56] and is processed first, byte 7 is key_i[7:0].
- hash_ready_o  output  1  level; high while hash_val_o holds the result for the last accepted key.
- hash_val_o  output  32  hash index, zero-extended.

Behaviour:
- Reset is synchronous, active-high, on clk:
  - hash_ready_o=0, hash_val_o=0.
  - Internal accumulator h=0, byte counter=0, state IDLE.
  - Reset mid-computation aborts it; no ready is produced.
- States: IDLE, RUN.
- Start, from any state, at rising edge N with start_i=1:
  - Latch key_i into the key register; h<=0; cnt<=0; state<=RUN.
  - hash_ready_o<=0 on this same edge, so a stale ready is never visible one cycle after start.
  - hash_val_o keeps its old value until the new result.
  - start_i while in RUN restarts with the new key and discards the old computation.
- RUN, each edge without start_i:
  - Take byte b = key_reg byte[cnt].
  - h <= rotl32(h,5) XOR {24'b0,b}; cnt<=cnt+1.
- RUN, edge processing byte 7 (edge N+8):
  - Compute hn = the updated h.
  - hash_val_o <= zero-extend((hn XOR (hn>>16))[HASH_BITS-1:0]).
  - hash_ready_o<=1; state<=IDLE.
- Latency: hash_ready_o rises exactly 8 edges after the sampling edge. One request in flight.
- IDLE: outputs hold (ready stays 1, value stable) until the next start or reset.
- Arithmetic: all 32-bit modulo; rotl32 is a circular left rotate by 5; no multipliers.
- Determinism: identical keys always give an identical hash_val_o, independent of history.
- start_i is only sampled at edges. A multi-cycle start_i re-samples every cycle, and ready appears 8 edges after the last high edge.
- key_i may change after the sampling edge without affecting the result.

Test Plan:
- Reset then idle:
  - hash_ready_o=0, hash_val_o=0.
  - start_i=0 for 20 cycles leaves both unchanged.
- key=0x0000_0000_0000_0001, 1-cycle start at edge N:
  - ready=0 after edge N, ready=1 after edge N+8.
  - hash_val_o=0x00000001; holds thereafter.
- key=0x0100_0000_0000_0000 -> hash_val_o=0x00000008.
- key=0x0A00_0000_0000_0000 -> hash_val_o=0x00000050.
- key=0 -> hash_val_o=0.
- Back-to-back: issue key A, and 3 cycles later key B=0x0000_0000_0000_0001:
  - No ready for A.
  - ready 8 edges after B's start, value 0x1.
- Reset asserted at cycle 4 of RUN:
  - Outputs return to 0; no ready.
  - A subsequent start computes correctly.
- Random keys with HASH_BITS=10: hash_val_o<1024, bits[31:10]=0, and the result matches a software model.
